// File: rtl/ewb_l2_if.sv
// Bus bundle for the L2 eviction write buffer: the enqueue port from the L2
// controller, the refill lookup port and the pmem write port.
interface ewb_l2_if #(
    parameter int width      = 256,
    parameter int addr_width = 27
);
    logic                  enq;
    logic [addr_width-1:0] enq_addr;
    logic [width-1:0]      enq_data;
    logic                  full;
    logic                  empty;
    logic [addr_width-1:0] lookup_addr;
    logic                  lookup_hit;
    logic [width-1:0]      lookup_data;
    logic                  pmem_write;
    logic [31:0]           pmem_address;
    logic [width-1:0]      pmem_wdata;
    logic                  pmem_resp;

    modport slave (
        input  enq, enq_addr, enq_data, lookup_addr, pmem_resp,
        output full, empty, lookup_hit, lookup_data, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output enq, enq_addr, enq_data, lookup_addr, pmem_resp,
        input  full, empty, lookup_hit, lookup_data, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/ewb_l2.sv
// Eviction write buffer: coalescing FIFO of dirty L2 lines drained to pmem in
// order, with refill forwarding from the youngest matching entry.
module ewb_l2 #(
    parameter int width      = 256,
    parameter int depth      = 4,
    parameter int addr_width = 27
) (
    input  logic        clk,
    input  logic        rst,
    ewb_l2_if.slave     bus
);
    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [depth-1:0]      r_valid;
    logic [addr_width-1:0] r_addr [depth];
    logic [width-1:0]      r_data [depth];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_head_busy;
    logic                  w_pop;
    logic                  w_coal_hit;
    logic [PTR_W-1:0]      w_coal_idx;
    logic                  w_alloc;
    logic                  w_lk_hit;
    logic [PTR_W-1:0]      w_lk_idx;

    assign w_head_busy = (r_state == S_WRITE);
    assign w_pop       = w_head_busy && bus.pmem_resp;

    // The head being written to pmem is frozen; a new copy of its line gets its own entry.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = '0;
        for (int i = 0; i < depth; i++) begin
            if (r_valid[i] && (r_addr[i] == bus.enq_addr) &&
                !(w_head_busy && (PTR_W'(i) == r_head))) begin
                w_coal_hit = 1'b1;
                w_coal_idx = PTR_W'(i);
            end
        end
    end

    assign w_alloc = bus.enq && !w_coal_hit && !r_full;

    // Scan oldest to youngest so the last match, nearest to tail, wins.
    always_comb begin
        logic [PTR_W-1:0] w_scan;
        w_lk_hit = 1'b0;
        w_lk_idx = '0;
        w_scan   = '0;
        for (int k = 0; k < depth; k++) begin
            w_scan = r_head + PTR_W'(k);
            if (r_valid[w_scan] && (r_addr[w_scan] == bus.lookup_addr)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = w_scan;
            end
        end
    end

    assign bus.lookup_hit  = w_lk_hit;
    assign bus.lookup_data = w_lk_hit ? r_data[w_lk_idx] : '0;

    always_comb begin
        w_count_next = r_count;
        if (w_alloc && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_alloc && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(depth));
            r_empty <= (w_count_next == '0);
        end
    end

    // NOTE: the line storage has no reset; the valid bits alone decide whether
    // an entry is visible, so clearing them is enough and keeps the array plain RAM.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= bus.enq_addr;
            r_data[r_tail] <= bus.enq_data;
        end else if (bus.enq && w_coal_hit) begin
            r_data[w_coal_idx] <= bus.enq_data;
        end
    end

    assign bus.full  = r_full;
    assign bus.empty = r_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next     = r_state;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = 32'({r_addr[r_head], 5'b0});
                bus.pmem_wdata   = r_data[r_head];
                if (bus.pmem_resp) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ewb_l2.sv
// Self-checking bench for ewb_l2: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the buffer.
module tb_ewb_l2;
    localparam int W  = 256;
    localparam int AW = 27;
    localparam int D  = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    ewb_l2_if #(.width(W), .addr_width(AW)) bus ();

    ewb_l2 #(.width(W), .depth(D), .addr_width(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: index 0 is the oldest line; m_busy means pmem is writing m_q[0].
    ent_t m_q[$];
    bit   m_busy;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic compare_outputs();
        bit           hit;
        logic [W-1:0] ld;
        hit = 1'b0;
        ld  = '0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (!hit && m_q[i].addr == bus.lookup_addr) begin
                hit = 1'b1;
                ld  = m_q[i].data;
            end
        end
        check("full", bus.full, m_q.size() == D);
        check("empty", bus.empty, m_q.size() == 0);
        check("pmem_write", bus.pmem_write, m_busy);
        check("pmem_address", bus.pmem_address, m_busy ? 32'({m_q[0].addr, 5'b0}) : 32'h0);
        check("pmem_wdata", bus.pmem_wdata, m_busy ? m_q[0].data : '0);
        check("lookup_hit", bus.lookup_hit, hit);
        check("lookup_data", bus.lookup_data, ld);
    endtask

    task automatic model_edge(input bit e, input logic [AW-1:0] a, input logic [W-1:0] d,
                              input bit resp, input bit r);
        int pre;
        int ci;
        int lo;
        if (r) begin
            m_q.delete();
            m_busy = 1'b0;
            return;
        end
        pre = m_q.size();
        ci  = -1;
        lo  = m_busy ? 1 : 0;
        if (e) begin
            for (int i = pre - 1; i >= lo; i--) begin
                if (ci < 0 && m_q[i].addr == a) ci = i;
            end
            if (ci >= 0) m_q[ci].data = d;
            else if (pre < D) m_q.push_back('{addr: a, data: d});
        end
        if (m_busy && resp) begin
            void'(m_q.pop_front());
            m_busy = 1'b0;
        end else if (!m_busy && pre > 0) begin
            m_busy = 1'b1;
        end
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances model and clock.
    task automatic step(input bit e, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input bit resp, input logic [AW-1:0] la, input bit r);
        bus.enq         = e;
        bus.enq_addr    = a;
        bus.enq_data    = d;
        bus.pmem_resp   = resp;
        bus.lookup_addr = la;
        rst             = r;
        @(negedge clk);
        compare_outputs();
        model_edge(e, a, d, resp, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] la);
        step(1'b0, '0, '0, 1'b0, la, 1'b0);
    endtask

    task automatic drain_all(input string tag, output int n_pops);
        int budget;
        n_pops = 0;
        budget = 0;
        while (m_q.size() > 0 && budget < 50) begin
            if (bus.pmem_write) n_pops++;
            step(1'b0, '0, '0, 1'b1, '0, 1'b0);
            budget++;
        end
        if (budget >= 50) check({tag, "_drain_timeout"}, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d1, d2, d3, dx;
        int           n;

        bus.enq = 1'b0; bus.enq_addr = '0; bus.enq_data = '0;
        bus.pmem_resp = 1'b0; bus.lookup_addr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_q.delete();
        m_busy = 1'b0;

        // Single line: enqueue, write issued after one idle cycle, held until resp.
        step(1'b1, 27'h10, {32{8'hAA}}, 1'b0, 27'h10, 1'b0);
        check("t1_empty", bus.empty, 1'b0);
        check("t1_hit", bus.lookup_hit, 1'b1);
        idle(27'h10);
        check("t1_write", bus.pmem_write, 1'b1);
        check("t1_addr", bus.pmem_address, 32'h0000_0200);
        check("t1_wdata", bus.pmem_wdata, {32{8'hAA}});
        for (int i = 0; i < 3; i++) begin
            idle(27'h10);
            check("t1_hold_addr", bus.pmem_address, 32'h0000_0200);
        end
        step(1'b0, '0, '0, 1'b1, 27'h10, 1'b0);
        check("t1_done_write", bus.pmem_write, 1'b0);
        check("t1_done_empty", bus.empty, 1'b1);

        // Fill to full, drop a fifth line, drain in order.
        for (int k = 0; k < 4; k++) step(1'b1, 27'h100 + 27'(k), rand_line(), 1'b0, 27'h104, 1'b0);
        check("t2_full", bus.full, 1'b1);
        step(1'b1, 27'h104, rand_line(), 1'b0, 27'h104, 1'b0);
        check("t2_still_full", bus.full, 1'b1);
        check("t2_dropped", bus.lookup_hit, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("t2_order", bus.pmem_address, 32'({27'h100 + 27'(k), 5'b0}));
            step(1'b0, '0, '0, 1'b1, '0, 1'b0);
            check("t2_gap", bus.pmem_write, 1'b0);
            if (k < 3) idle('0);
        end
        check("t2_empty", bus.empty, 1'b1);

        // Coalesce into a waiting entry.
        d1 = rand_line();
        d2 = rand_line();
        step(1'b1, 27'h55, d1, 1'b0, 27'h55, 1'b0);
        step(1'b1, 27'h55, d2, 1'b0, 27'h55, 1'b0);
        check("t3_wdata", bus.pmem_wdata, d2);
        step(1'b0, '0, '0, 1'b1, 27'h55, 1'b0);
        check("t3_one_entry", bus.empty, 1'b1);

        // Same line while its head copy is in flight: new entry, lookup sees the new data.
        dx = rand_line();
        d3 = rand_line();
        step(1'b1, 27'h55, dx, 1'b0, 27'h55, 1'b0);
        idle(27'h55);
        step(1'b1, 27'h55, d3, 1'b0, 27'h55, 1'b0);
        check("t4_hit", bus.lookup_hit, 1'b1);
        check("t4_data", bus.lookup_data, d3);
        check("t4_head_data", bus.pmem_wdata, dx);
        step(1'b0, '0, '0, 1'b1, 27'h55, 1'b0);
        idle(27'h55);
        check("t4_second_addr", bus.pmem_address, 32'({27'h55, 5'b0}));
        check("t4_second_data", bus.pmem_wdata, d3);
        step(1'b0, '0, '0, 1'b1, 27'h55, 1'b0);
        check("t4_empty", bus.empty, 1'b1);

        // Enq while full and popping is dropped; non-full enq+pop keeps count.
        for (int k = 0; k < 4; k++) step(1'b1, 27'h200 + 27'(k), rand_line(), 1'b0, '0, 1'b0);
        step(1'b1, 27'h204, rand_line(), 1'b1, 27'h204, 1'b0);
        check("t5_not_full", bus.full, 1'b0);
        check("t5_dropped", bus.lookup_hit, 1'b0);
        drain_all("t5a", n);
        check("t5_drained3", n, 3);
        step(1'b1, 27'h300, rand_line(), 1'b0, '0, 1'b0);
        step(1'b1, 27'h301, rand_line(), 1'b0, '0, 1'b0);
        step(1'b1, 27'h302, rand_line(), 1'b1, '0, 1'b0);
        drain_all("t5b", n);
        check("t5_drained2", n, 2);

        // Reset during WRITE abandons the line.
        step(1'b1, 27'h400, rand_line(), 1'b0, 27'h400, 1'b0);
        idle(27'h400);
        check("t6_write", bus.pmem_write, 1'b1);
        step(1'b0, '0, '0, 1'b0, 27'h400, 1'b1);
        check("t6_write_off", bus.pmem_write, 1'b0);
        check("t6_empty", bus.empty, 1'b1);
        check("t6_hit", bus.lookup_hit, 1'b0);
        check("t6_data", bus.lookup_data, '0);

        // Random traffic over a small address pool to exercise coalescing and forwarding.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) < 6,
                 27'h100 + 27'($urandom_range(0, 5)),
                 rand_line(),
                 $urandom_range(0, 9) < 3,
                 27'h100 + 27'($urandom_range(0, 6)),
                 $urandom_range(0, 255) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ewb_l2.md
Name: ewb_l2

Overview:
- Eviction write buffer between the L2 data array and physical memory.
- On eviction, the L2 controller pushes the dirty 256-bit line and its line address into the buffer.
- The buffer drains entries to pmem in FIFO order, one line per pmem transaction.
- It forwards buffered lines to L2 refills whose address matches an entry, so a read never bypasses a pending write.

Parameters:
- width, 256, line width in bits; matches the L2 data array.
- depth, 4, number of buffer entries; must be a power of 2 and at least 2.
- addr_width, 27, line-address bits (32-bit byte address minus 5 offset bits).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-high.
- enq  input  1  push request for one dirty line.
- enq_addr  input  addr_width  line address of the pushed line.
- enq_data  input  width  line data, sampled on the enq cycle.
- full  output  1  no free entry; registered.
- empty  output  1  no valid entry; registered.
- lookup_addr  input  addr_width  line address of an L2 refill.
- lookup_hit  output  1  a valid entry matches lookup_addr; combinational.
- lookup_data  output  width  data of the matching entry; 0 when there is no hit.
- pmem_write  output  1  write request to physical memory.
- pmem_address  output  32  byte address, {head_addr, 5'b0}.
- pmem_wdata  output  width  data of the head entry.
- pmem_resp  input  1  pmem write completed.

Behaviour:
- Reset: clears all valid bits and sets head = tail = count = 0 and state IDLE.
  - After reset: full=0, empty=1, pmem_write=0, pmem_address=0, pmem_wdata=0, lookup_hit=0, lookup_data=0.
  - Reset in WRITE abandons the transaction: pmem_write=0 on the next cycle and the entry is discarded.
- Storage: per-entry valid, addr and data registers, plus circular head/tail pointers (log2(depth) bits, wrapping at depth-1 to 0) and a count of log2(depth)+1 bits.
- Enqueue (enq=1):
  - Coalesce case: if a valid entry other than the head-in-WRITE has addr == enq_addr, its data is overwritten with enq_data. Count and tail are unchanged.
  - Otherwise, if full=0, the line is written at tail, tail increments and count increments.
  - If full=1 and no coalesce target exists, enq is ignored; the controller must stall on full.
  - full is evaluated on the pre-update state, so an enq in the same cycle as a pop while full is ignored.
- Drain FSM, two states:
  - IDLE: pmem_write=0. If count != 0, go to WRITE on the next edge.
  - WRITE: pmem_write=1 and pmem_address/pmem_wdata are driven from head, stable until pmem_resp.
    - On pmem_resp=1: clear head valid, increment head, decrement count, return to IDLE.
    - There is one idle cycle between consecutive writes.
- Simultaneous enq and pop (not full): count is unchanged, the head and tail pointers each advance.
- Lookup:
  - Compares all valid entries, including the head while in WRITE until it is popped.
  - If several entries match (possible only when the head is in WRITE and a newer copy exists), the youngest, i.e. the one nearest to tail, wins.
  - Lookup does not see a same-cycle enq; the new data is visible the next cycle.
- full = (count == depth); empty = (count == 0). Both are registered and updated on the edge.
- pmem_address and pmem_wdata are driven to 0 in IDLE.

Test Plan:
- Reset, then one enq (addr 0x0000010, data all 0xAA) -> next cycle empty=0; following cycle pmem_write=1 with pmem_address=0x00000200. Hold pmem_resp low for 3 cycles -> outputs stable. Assert pmem_resp -> next cycle pmem_write=0, empty=1.
- Fill with 4 distinct addrs A0..A3 while pmem_resp is held low -> full=1 after the 4th enq. A 5th enq with new addr A4 -> ignored, count stays 4. Drain 4 -> pmem sees A0,A1,A2,A3 in order and head wraps to 0.
- Enq addr 0x55 with data D1, then addr 0x55 with data D2 while 0x55 is not at head-in-WRITE -> count=1, and the drained data is D2.
- Head addr 0x55 in WRITE, enq 0x55 with D3 -> new entry allocated, count=2. lookup 0x55 -> hit, returns D3. After pmem_resp, a second write of 0x55 with D3 follows.
- Full buffer, same cycle pmem_resp=1 and enq new addr -> enq dropped, count=3. Non-full count=2 with simultaneous enq and pop -> count stays 2.
- Reset asserted during WRITE -> next cycle pmem_write=0, empty=1, and lookup of the previously buffered addr -> hit=0, data=0.
